// File: rtl/warp_issue_arbiter.sv
// Round-robin issue arbiter: picks one eligible warp head per cycle into a
// single registered issue stage, with per-warp flush and an issue counter.
module warp_issue_arbiter #(
    parameter int NUM_WARPS = 8,
    parameter int DATA_BITS = 128,
    parameter int ALLOW_B2B = 1,
    localparam int WID_BITS = $clog2(NUM_WARPS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_WARPS-1:0]           ibuf_valid,
    output logic [NUM_WARPS-1:0]           ibuf_ready,
    input  logic [NUM_WARPS*DATA_BITS-1:0] ibuf_data,
    input  logic [NUM_WARPS-1:0]           warp_stall,
    input  logic                           flush_valid,
    input  logic [WID_BITS-1:0]            flush_wid,
    output logic                           issue_valid,
    input  logic                           issue_ready,
    output logic [WID_BITS-1:0]            issue_wid,
    output logic [DATA_BITS-1:0]           issue_data,
    output logic [31:0]                    issue_count
);

    logic                 full_q, full_d;
    logic [WID_BITS-1:0]  wid_q, wid_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [WID_BITS-1:0]  rr_ptr_q, rr_ptr_d;
    logic [31:0]          count_q, count_d;

    logic                 kill;
    logic                 fire;
    logic                 can_load;
    logic [NUM_WARPS-1:0] eligible;
    logic                 found;
    logic [WID_BITS-1:0]  grant_wid;
    logic [WID_BITS-1:0]  idx;
    logic                 grant_valid;

    always_comb begin
        kill        = flush_valid & full_q & (wid_q == flush_wid);
        // Reset masks the stage so a staged instruction is never issued mid-reset.
        issue_valid = full_q & ~kill & ~reset;
        fire        = issue_valid & issue_ready;
        can_load    = ~full_q | fire | kill;

        for (int w = 0; w < NUM_WARPS; w++) begin
            eligible[w] = ibuf_valid[w] & ~warp_stall[w]
                        & ~(flush_valid && (flush_wid == WID_BITS'(w)))
                        & ~((ALLOW_B2B == 0) && full_q && !fire && !kill
                            && (wid_q == WID_BITS'(w)));
        end

        found     = 1'b0;
        grant_wid = '0;
        idx       = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = rr_ptr_q + WID_BITS'(i);
            if (!found && eligible[idx]) begin
                found     = 1'b1;
                grant_wid = idx;
            end
        end
        grant_valid = found & can_load & ~reset;

        ibuf_ready = '0;
        ibuf_ready[grant_wid] = grant_valid;

        full_d   = full_q;
        wid_d    = wid_q;
        data_d   = data_q;
        rr_ptr_d = rr_ptr_q;
        count_d  = count_q;

        if (fire) begin
            count_d = count_q + 32'd1;
        end

        if (grant_valid) begin
            full_d   = 1'b1;
            wid_d    = grant_wid;
            data_d   = ibuf_data[DATA_BITS*grant_wid +: DATA_BITS];
            rr_ptr_d = grant_wid + WID_BITS'(1);
        end else if (fire || kill) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            full_q   <= 1'b0;
            wid_q    <= '0;
            data_q   <= '0;
            rr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            full_q   <= full_d;
            wid_q    <= wid_d;
            data_q   <= data_d;
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign issue_wid   = wid_q;
    assign issue_data  = data_q;
    assign issue_count = count_q;

endmodule
